// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: register offsets, CTRL bit indices and FSM encoding for uart_tx_periph
package uart_tx_pkg;
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_DIV  = 2'd1;
    localparam logic [1:0] ADDR_CTRL = 2'd2;
    localparam logic [1:0] ADDR_STAT = 2'd3;
    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_PAR_EN = 2;
    localparam int CTRL_CLR    = 7;
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO with clear, saturating count and sticky overflow
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     clr_i,
    input  logic [7:0]               data_i,
    output logic [7:0]               data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     overflow_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d, do_push, do_pop;
    assign empty_o    = count_q == '0;
    assign full_o     = count_q == CW'(DEPTH);
    assign do_pop     = pop_i & ~empty_o;
    // a push into a full FIFO still lands when the head leaves on the same edge
    assign do_push    = push_i & (~full_o | do_pop);
    assign data_o     = mem_q[rptr_q];
    assign overflow_o = ovf_q;
    assign count_o    = count_q;
    always_comb begin
        wptr_d  = clr_i ? '0 : wptr_q + AW'(do_push);
        rptr_d  = clr_i ? '0 : rptr_q + AW'(do_pop);
        count_d = clr_i ? '0 : count_q + CW'(do_push) - CW'(do_pop);
        ovf_d   = ~clr_i & (ovf_q | (push_i & ~do_push));
    end
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: rtl/uart_tx_periph.sv
// uart_tx_periph: memory-mapped 8N1 UART transmitter with FIFO, divisor and IRQ
// Optional even-parity bit (CTRL bit2) when UART_TX_PARITY_EN is defined.
module uart_tx_periph
    import uart_tx_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] DIV_RESET  = 8'd3
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       cs_i,
    input  logic       write_en_i,
    input  logic [1:0] addr_lsb_i,
    input  logic [7:0] data_in_i,
    output logic [7:0] rd_data_o,
    output logic       uart_tx_o,
    output logic       busy_o,
    output logic       irq_o
);
`ifdef UART_TX_PARITY_EN
    localparam logic PAR_IMPL = 1'b1;
`else
    localparam logic PAR_IMPL = 1'b0;
`endif
    state_t     state_q, state_d;
    logic [7:0] div_q, div_d, sdiv_q, sdiv_d, cnt_q, cnt_d, shift_q, shift_d, head;
    logic [2:0] ctrl_q, ctrl_d, bit_q, bit_d;
    logic       par_en_q, par_en_d, par_bit_q, par_bit_d;
    logic       wr, push, pop, clr, tick, full, empty, ovf;
    logic [$clog2(FIFO_DEPTH):0] count;
    assign wr    = cs_i & write_en_i;
    assign push  = wr && addr_lsb_i == ADDR_DATA;
    assign clr   = wr && addr_lsb_i == ADDR_CTRL && data_in_i[CTRL_CLR];
    assign pop   = state_q == ST_IDLE && ctrl_q[CTRL_ENABLE] && !empty;
    assign tick  = cnt_q == 8'd0;
    assign busy_o = state_q != ST_IDLE || !empty;
    assign irq_o  = empty & ctrl_q[CTRL_IRQ_EN] & ctrl_q[CTRL_ENABLE];
    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .push_i(push), .pop_i(pop), .clr_i(clr),
        .data_i(data_in_i), .data_o(head), .full_o(full), .empty_o(empty),
        .overflow_o(ovf), .count_o(count)
    );
    always_comb begin
        div_d     = (wr && addr_lsb_i == ADDR_DIV) ? data_in_i : div_q;
        ctrl_d    = (wr && addr_lsb_i == ADDR_CTRL) ? data_in_i[2:0] & {PAR_IMPL, 2'b11} : ctrl_q;
        rd_data_o = addr_lsb_i == ADDR_DIV  ? div_q :
                    addr_lsb_i == ADDR_CTRL ? {5'b0, ctrl_q} :
                    addr_lsb_i == ADDR_STAT ? {1'b0, 3'(count), ovf, empty, full, busy_o} : 8'h00;
    end
    // divisor and parity mode are frozen per frame in the shadow registers
    always_comb begin
        state_d   = state_q;
        sdiv_d    = sdiv_q;
        cnt_d     = tick ? sdiv_q : cnt_q - 8'd1;
        shift_d   = shift_q;
        bit_d     = bit_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = cnt_q;
                if (pop) begin
                    state_d   = ST_START;
                    sdiv_d    = div_q;
                    cnt_d     = div_q;
                    shift_d   = head;
                    bit_d     = 3'd0;
                    par_en_d  = ctrl_q[CTRL_PAR_EN];
                    par_bit_d = ^head;
                end
            end
            ST_START:  if (tick) state_d = ST_DATA;
            ST_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = par_en_q ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: if (tick) state_d = ST_STOP;
            ST_STOP:   if (tick) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end
    always_comb begin
        uart_tx_o = state_q == ST_START  ? 1'b0 :
                    state_q == ST_DATA   ? shift_q[0] :
                    state_q == ST_PARITY ? par_bit_q : 1'b1;
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            div_q     <= DIV_RESET;
            ctrl_q    <= '0;
            sdiv_q    <= '0;
            cnt_q     <= '0;
            shift_q   <= '0;
            bit_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            ctrl_q    <= ctrl_d;
            sdiv_q    <= sdiv_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_periph.sv
// tb_uart_tx_periph: random-stimulus bench comparing the serial line against frame arithmetic
module tb_uart_tx_periph;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam logic [1:0] A_DATA = 2'd0, A_DIV = 2'd1, A_CTRL = 2'd2, A_STAT = 2'd3;
    localparam int HN = 20000;
    logic       clk_i = 1'b0, rst_n_i = 1'b0, cs_i = 1'b0, write_en_i = 1'b0;
    logic [1:0] addr_lsb_i = 2'd0;
    logic [7:0] data_in_i = 8'h00;
    logic [7:0] rd_data_o;
    logic       uart_tx_o, busy_o, irq_o;
    int         cyc = 0, total = 0, bad = 0, wcyc = 0;
    logic       tx_h [HN], busy_h [HN], irq_h [HN];

    uart_tx_periph #(.FIFO_DEPTH(4), .DIV_RESET(8'd3)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .cs_i(cs_i), .write_en_i(write_en_i),
        .addr_lsb_i(addr_lsb_i), .data_in_i(data_in_i), .rd_data_o(rd_data_o),
        .uart_tx_o(uart_tx_o), .busy_o(busy_o), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;
    always @(negedge clk_i) begin
        if (cyc < HN) begin
            tx_h[cyc]   = uart_tx_o;
            busy_h[cyc] = busy_o;
            irq_h[cyc]  = irq_o;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        cs_i = 1'b1; write_en_i = 1'b1; addr_lsb_i = a; data_in_i = d;
        wcyc = cyc;
        @(posedge clk_i); #1;
        cs_i = 1'b0; write_en_i = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] v);
        addr_lsb_i = a; #1;
        v = rd_data_o;
    endtask

    task automatic wait_until(input int c);
        while (cyc <= c) begin
            @(posedge clk_i); #1;
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input int k, input bit pe);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (pe && k == 9) return ^d;
        return 1'b1;
    endfunction

    task automatic check_frame(input int s, input logic [7:0] d, input int dv, input bit pe, input string nm);
        int n, w;
        logic [31:0] obs, ex;
        n = pe ? 11 : 10;
        w = dv + 1;
        wait_until(s + n * w);
        chk($sformatf("%s %h idle-before", nm, d), 32'(tx_h[s-1]), 32'd1);
        for (int k = 0; k < n; k++) begin
            obs = '0;
            for (int j = 0; j < w; j++) obs[j] = tx_h[s + k * w + j];
            ex = frame_bit(d, k, pe) ? (32'hFFFF_FFFF >> (32 - w)) : 32'd0;
            chk($sformatf("%s %h bit%0d", nm, d, k), obs, ex);
        end
        chk($sformatf("%s %h idle-after", nm, d), 32'(tx_h[s + n * w]), 32'd1);
    endtask

    function automatic logic [7:0] stat(input int cnt, input bit ov, input bit bsy);
        return {1'b0, 3'(cnt), ov, cnt == 0, cnt == 4, bsy};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s, s_last, dv, w;
        logic [7:0] d, b, v;
        logic [31:0] obs;
        bit pe, ovf;
        logic [7:0] q [$];
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset tx", 32'(uart_tx_o), 32'd1);
        chk("reset busy", 32'(busy_o), 32'd0);
        chk("reset irq", 32'(irq_o), 32'd0);
        @(negedge clk_i) rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        rd(A_STAT, v); chk("reset status", v, 8'h04);
        rd(A_DIV, v);  chk("reset div", v, 8'h03);
        rd(A_CTRL, v); chk("reset ctrl", v, 8'h00);
        rd(A_DATA, v); chk("data read", v, 8'h00);

        // single frames: fixed A5/07/03 then random bytes, divisors and parity mode
        for (int i = 0; i < 6; i++) begin
            dv = i == 0 ? 3 : int'($urandom_range(0, 4));
            d  = i == 0 ? 8'hA5 : i == 1 ? 8'h07 : i == 2 ? 8'h03 : 8'($urandom);
            pe = (i == 1 || i == 2) || (i > 2 && $urandom_range(0, 1) == 1);
            wr(A_DIV, 8'(dv));
            wr(A_CTRL, {5'b0, pe, 2'b01});
            rd(A_CTRL, v); chk("ctrl readback", v, {5'b0, pe & PAR, 2'b01});
            rd(A_DIV, v);  chk("div readback", v, 8'(dv));
            wr(A_STAT, 8'hFF);
            wr(A_DATA, d);
            s = wcyc + 2;
            check_frame(s, d, dv, pe & PAR, "single");
            w = (pe & PAR ? 11 : 10) * (dv + 1);
            chk("busy during", 32'(busy_h[s + w - 1]), 32'd1);
            chk("busy falls", 32'(busy_h[s + w]), 32'd0);
        end

        // fill with ENABLE=0, overflow, then enable and push on the pop edge
        wr(A_CTRL, 8'h00);
        dv = int'($urandom_range(0, 2));
        wr(A_DIV, 8'(dv));
        ovf = 1'b0;
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            wr(A_DATA, b);
            if (q.size() < 4) q.push_back(b); else ovf = 1'b1;
            rd(A_STAT, v); chk($sformatf("fill status %0d", i), v, stat(q.size(), ovf, 1'b1));
        end
        chk("fill irq", 32'(irq_o), 32'd0);
        wr(A_CTRL, 8'h03);
        s = wcyc + 2;
        b = 8'($urandom);
        wr(A_DATA, b);
        q.push_back(b);
        s_last = s;
        for (int k = 0; k < q.size(); k++) begin
            check_frame(s, q[k], dv, 1'b0, "b2b");
            s_last = s;
            s = s + 10 * (dv + 1) + 1;
        end
        chk("irq before last pop", 32'(irq_h[s_last - 1]), 32'd0);
        chk("irq after last pop", 32'(irq_h[s_last]), 32'd1);
        chk("irq after last frame", 32'(irq_h[s_last + 10 * (dv + 1)]), 32'd1);
        rd(A_STAT, v); chk("drained status", v, stat(0, ovf, 1'b0));

        // divisor change mid-frame only affects the following frame
        wr(A_CTRL, 8'h01);
        wr(A_DIV, 8'd3);
        wr(A_DATA, 8'h3C);
        s = wcyc + 2;
        b = 8'($urandom);
        wr(A_DATA, b);
        wait_until(s + 10);
        wr(A_DIV, 8'd1);
        check_frame(s, 8'h3C, 3, 1'b0, "divold");
        check_frame(s + 41, b, 1, 1'b0, "divnew");

        // CLR with one frame in flight and three queued
        wr(A_DATA, 8'($urandom));
        s = wcyc + 2;
        d = data_in_i;
        for (int i = 0; i < 3; i++) wr(A_DATA, 8'($urandom));
        wr(A_CTRL, 8'h81);
        rd(A_STAT, v); chk("clr status", v, stat(0, 1'b0, 1'b1));
        check_frame(s, d, 1, 1'b0, "clr");
        wait_until(s + 52);
        obs = '0;
        for (int j = 0; j < 32; j++) obs[j] = tx_h[s + 20 + j];
        chk("clr quiet line", obs, 32'hFFFF_FFFF);
        rd(A_STAT, v); chk("clr final status", v, stat(0, 1'b0, 1'b0));

        // asynchronous reset in the middle of a frame
        wr(A_DATA, 8'($urandom));
        s = wcyc + 2;
        wait_until(s + 3);
        chk("rst frame started", 32'(tx_h[s]), 32'd0);
        #2 rst_n_i = 1'b0;
        #1;
        chk("rst tx", 32'(uart_tx_o), 32'd1);
        chk("rst busy", 32'(busy_o), 32'd0);
        chk("rst irq", 32'(irq_o), 32'd0);
        rd(A_STAT, v); chk("rst status", v, 8'h04);
        @(negedge clk_i) rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        rd(A_DIV, v);  chk("rst div", v, 8'h03);
        rd(A_CTRL, v); chk("rst ctrl", v, 8'h00);
        repeat (5) @(posedge clk_i);
        #1;
        chk("rst stays idle", 32'(uart_tx_o), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
